// File: rtl/spm_pkg.sv
// Shared types and helpers for the serial-parallel multiplier driver.
package spm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        DONE
    } spm_drv_state_t;

    // Wide enough to hold 2*SIZE, so a full product's worth of bits can be counted.
    function automatic int spm_cnt_w(input int size);
        return $clog2(2 * size + 1);
    endfunction

endpackage

// File: rtl/spm_sipo_capture.sv
// Serial-in parallel-out product register: collects 2*SIZE chain bits LSB-first,
// starting CHAIN_LAT cycles after the first multiplier bit enters the chain.
module spm_sipo_capture #(
    parameter int SIZE      = 32,
    parameter int CHAIN_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              p_i,
    output logic [2*SIZE-1:0] prod,
    output logic              last,
    output logic              full
);
    import spm_pkg::*;

    localparam int CNT_W = spm_cnt_w(SIZE);

    logic [CHAIN_LAT:0] arm;
    logic               active;
    logic               cap_en;
    logic [CNT_W-1:0]   cap_cnt;

    // start marks the clear cycle, so arm[0] lines up with the first shifted y bit.
    assign cap_en = arm[CHAIN_LAT] || active;
    assign last   = cap_en && (cap_cnt == CNT_W'(2 * SIZE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            arm     <= '0;
            active  <= 1'b0;
            cap_cnt <= '0;
            prod    <= '0;
            full    <= 1'b0;
        end else begin
            arm[0] <= start;
            for (int i = 1; i <= CHAIN_LAT; i++) begin
                arm[i] <= arm[i-1];
            end
            if (start) begin
                full <= 1'b0;
            end else if (last) begin
                full <= 1'b1;
            end
            if (cap_en) begin
                prod    <= {p_i, prod[2*SIZE-1:1]};
                cap_cnt <= last ? '0 : cap_cnt + 1'b1;
                active  <= !last;
            end
        end
    end

endmodule

// File: rtl/spm_serial_driver.sv
// Front/back end for the spm carry-save chain: parallel multiplicand, serial
// sign-extended multiplier, serial product collected into a 2*SIZE-bit result.
module spm_serial_driver #(
    parameter int SIZE      = 32,
    parameter int CHAIN_LAT = 1,
    parameter bit SIGNED    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE-1:0]   mc,
    input  logic [SIZE-1:0]   mp,
    output logic [SIZE-1:0]   x_o,
    output logic              y_o,
    output logic              chain_clr,
    input  logic              p_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*SIZE-1:0] prod
);
    import spm_pkg::*;

    localparam int CNT_W = spm_cnt_w(SIZE);

    spm_drv_state_t   state;
    spm_drv_state_t   state_n;
    logic [SIZE-1:0]  mpr;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             fill;
    logic             shift_last;
    logic             cap_last;
    logic             cap_full;

    assign accept     = in_valid && in_ready;
    assign fill       = SIGNED ? mpr[SIZE-1] : 1'b0;
    assign shift_last = (cnt == CNT_W'(2 * SIZE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Completion is driven by the capture side, so DRAIN naturally vanishes when CHAIN_LAT=0.
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        chain_clr = 1'b0;
        y_o       = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_n = CLEAR;
                end
            end
            CLEAR: begin
                chain_clr = 1'b1;
                state_n   = SHIFT;
            end
            SHIFT: begin
                y_o = mpr[0];
                if (cap_last) begin
                    state_n = DONE;
                end else if (shift_last) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                y_o = mpr[0];
                if (cap_last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                out_valid = cap_full;
                if (cap_full && out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // After 2*SIZE shifts mpr is all extension bits, which DRAIN keeps feeding the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_o <= '0;
            mpr <= '0;
            cnt <= '0;
        end else begin
            if (accept) begin
                x_o <= mc;
                mpr <= mp;
            end
            if (state == CLEAR) begin
                cnt <= '0;
            end else if (state == SHIFT) begin
                mpr <= {fill, mpr[SIZE-1:1]};
                cnt <= cnt + 1'b1;
            end
        end
    end

    spm_sipo_capture #(
        .SIZE      (SIZE),
        .CHAIN_LAT (CHAIN_LAT)
    ) u_capture (
        .clk   (clk),
        .rst   (rst),
        .start (chain_clr),
        .p_i   (p_i),
        .prod  (prod),
        .last  (cap_last),
        .full  (cap_full)
    );

endmodule

// File: tb/tb_spm_serial_driver.sv
// Bench for spm_serial_driver with a behavioural one-cycle csa chain and an
// arithmetic reference model for the product.
module tb_spm_serial_driver;

    localparam int SIZE      = 8;
    localparam int CHAIN_LAT = 1;
    localparam bit SIGNED_P  = 1'b1;
    localparam int LAT       = 1 + 2 * SIZE + CHAIN_LAT;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  mc        = '0;
    logic [7:0]  mp        = '0;
    logic        p_i       = 1'b0;
    logic        in_ready;
    logic [7:0]  x_o;
    logic        y_o;
    logic        chain_clr;
    logic        out_valid;
    logic [15:0] prod;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spm_serial_driver #(
        .SIZE      (SIZE),
        .CHAIN_LAT (CHAIN_LAT),
        .SIGNED    (SIGNED_P)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mc        (mc),
        .mp        (mp),
        .x_o       (x_o),
        .y_o       (y_o),
        .chain_clr (chain_clr),
        .p_i       (p_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod)
    );

    // Behavioural chain: accumulates y_k * x * 2^k and emits bit k one cycle later.
    logic [15:0] acc = '0;
    logic [15:0] xext;
    logic [15:0] acc_next;
    int          ch_k = 0;

    assign xext     = {{8{x_o[7] & SIGNED_P}}, x_o};
    assign acc_next = acc + (y_o ? (xext << ch_k) : 16'd0);

    always @(posedge clk) begin
        if (chain_clr) begin
            acc  <= '0;
            ch_k <= 0;
            p_i  <= 1'b0;
        end else if (ch_k < 16) begin
            acc  <= acc_next;
            p_i  <= acc_next[ch_k];
            ch_k <= ch_k + 1;
        end
    end

    function automatic logic [15:0] refProd(input logic [7:0] a, input logic [7:0] b);
        longint sa;
        longint sb;
        sa = SIGNED_P ? longint'($signed(a)) : longint'(a);
        sb = SIGNED_P ? longint'($signed(b)) : longint'(b);
        return 16'(sa * sb);
    endfunction

    function automatic logic [15:0] refYStream(input logic [7:0] b);
        longint sb;
        sb = SIGNED_P ? longint'($signed(b)) : longint'(b);
        return 16'(sb);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_chain_clr"}, 32'(chain_clr), 32'd0);
        checkOutput({tag, "_x_o"}, 32'(x_o), 32'd0);
        checkOutput({tag, "_y_o"}, 32'(y_o), 32'd0);
        checkOutput({tag, "_prod"}, 32'(prod), 32'd0);
    endtask

    // Called #1 after an edge; returns #1 after the accept edge (DUT in its clear cycle).
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) checkOutput("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        mc       = a;
        mp       = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic runOp(input logic [7:0] a, input logic [7:0] b, input int hold);
        logic [15:0] ys = '0;
        logic [15:0] exp_p;
        int cyc  = 0;
        int clrs = 0;
        exp_p     = refProd(a, b);
        out_ready = (hold == 0);
        applyStimulus(a, b);
        while (!out_valid && cyc < 100) begin
            if (chain_clr) clrs++;
            if (cyc >= 1 && cyc <= 16) ys[cyc-1] = y_o;
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("latency", 32'(cyc), 32'(LAT));
        checkOutput("clr_pulses", 32'(clrs), 32'd1);
        checkOutput("y_stream", 32'(ys), 32'(refYStream(b)));
        checkOutput("prod", 32'(prod), 32'(exp_p));
        checkOutput("x_o_hold", 32'(x_o), 32'(a));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            mc       = 8'($urandom);
            mp       = 8'($urandom);
            @(posedge clk); #1;
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_prod", 32'(prod), 32'(exp_p));
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_hs_out_valid", 32'(out_valid), 32'd0);
        checkOutput("post_hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] qa [4];
        logic [7:0] qb [4];
        int idx;
        int got;
        int n;
        int seen;

        $display("[TB] reset");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed products");
        runOp(8'd3, 8'd5, 0);
        runOp(8'hFF, 8'hFF, 0);
        runOp(8'h80, 8'h80, 0);
        runOp(8'h7F, 8'h80, 0);
        checkOutput("neg_min_squared", 32'(refProd(8'h80, 8'h80)), 32'h4000);

        $display("[TB] back-pressure");
        runOp(8'h5A, 8'hC3, 20);

        $display("[TB] random products");
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            runOp(a, b, 0);
        end

        $display("[TB] reset mid-shift");
        out_ready = 1'b1;
        applyStimulus(8'($urandom), 8'($urandom));
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkResetValues("abort");
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        checkOutput("abort_no_valid", 32'(seen), 32'd0);
        runOp(8'd2, 8'd7, 0);

        $display("[TB] back-to-back");
        for (int i = 0; i < 4; i++) begin
            qa[i] = 8'($urandom);
            qb[i] = 8'($urandom);
        end
        idx = 0;
        got = 0;
        n   = 0;
        while (got < 4 && n < 600) begin
            out_ready = 1'($urandom_range(0, 1));
            if (idx < 4) begin
                in_valid = 1'b1;
                mc       = qa[idx];
                mp       = qb[idx];
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid && out_ready) begin
                checkOutput("b2b_prod", 32'(prod), 32'(refProd(qa[got], qb[got])));
                got++;
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("b2b_count", 32'(got), 32'd4);
        checkOutput("b2b_accepted", 32'(idx), 32'd4);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        checkOutput("b2b_no_extra", 32'(seen), 32'd0);
        checkOutput("b2b_idle", 32'(in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
